// File: rtl/paillier_lite_cfg_master.sv
// AXI4-Lite master that programs mode/test_times into the Paillier accelerator, launches it and polls status until done.
// Optional poll timeout: define PAILLIER_CFG_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog.
module paillier_lite_cfg_master #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    POLL_GAP       = 16,
    parameter int                    TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  S_LITE_AXI_ACLK,
    input  logic                  S_LITE_AXI_ARESETN,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [63:0]           test_times,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           status,
    output logic [ADDR_WIDTH-1:0] M_AWADDR,
    output logic [2:0]            M_AWPROT,
    output logic                  M_AWVALID,
    input  logic                  M_AWREADY,
    output logic [31:0]           M_WDATA,
    output logic [3:0]            M_WSTRB,
    output logic                  M_WVALID,
    input  logic                  M_WREADY,
    input  logic [1:0]            M_BRESP,
    input  logic                  M_BVALID,
    output logic                  M_BREADY,
    output logic [ADDR_WIDTH-1:0] M_ARADDR,
    output logic [2:0]            M_ARPROT,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    input  logic [31:0]           M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RVALID,
    output logic                  M_RREADY
);

    localparam logic [ADDR_WIDTH-1:0] OFF_MODE   = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] OFF_CTRL   = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] OFF_TT_LO  = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] OFF_TT_HI  = ADDR_WIDTH'(8'h0C);
    localparam logic [ADDR_WIDTH-1:0] OFF_STATUS = ADDR_WIDTH'(8'h10);
    localparam logic [31:0]           GAP_LIM    = 32'(POLL_GAP);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_BRESP, S_GAP, S_READ, S_RDATA, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        aw_ok_q, aw_ok_d;
    logic        w_ok_q, w_ok_d;
    logic [31:0] gap_q, gap_d;
    logic [31:0] status_q, status_d;
    logic [1:0]  mode_q, mode_d;
    logic [63:0] tt_q, tt_d;
    logic        timeout;

`ifdef PAILLIER_CFG_TIMEOUT_EN
    localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);
    logic [31:0] to_q, to_d;

    assign timeout = (to_q >= TO_LIM);
    assign to_d    = (state_q == S_GAP || state_q == S_READ || state_q == S_RDATA) ? to_q + 32'd1 : 32'd0;

    always_ff @(posedge S_LITE_AXI_ACLK or posedge S_LITE_AXI_ARESETN) begin
        if (S_LITE_AXI_ARESETN) to_q <= '0;
        else                    to_q <= to_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge S_LITE_AXI_ACLK or posedge S_LITE_AXI_ARESETN) begin
        if (S_LITE_AXI_ARESETN) state_q <= S_IDLE;
        else                    state_q <= state_d;
    end

    always_ff @(posedge S_LITE_AXI_ACLK or posedge S_LITE_AXI_ARESETN) begin
        if (S_LITE_AXI_ARESETN) begin
            idx_q    <= '0;
            aw_ok_q  <= 1'b0;
            w_ok_q   <= 1'b0;
            gap_q    <= '0;
            status_q <= '0;
        end else begin
            idx_q    <= idx_d;
            aw_ok_q  <= aw_ok_d;
            w_ok_q   <= w_ok_d;
            gap_q    <= gap_d;
            status_q <= status_d;
        end
    end

    // Captured launch parameters are only observed while busy, so they need no reset.
    always_ff @(posedge S_LITE_AXI_ACLK) begin
        mode_q <= mode_d;
        tt_q   <= tt_d;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        aw_ok_d  = 1'b0;
        w_ok_d   = 1'b0;
        gap_d    = (state_q == S_GAP) ? gap_q + 32'd1 : 32'd0;
        status_d = status_q;
        mode_d   = mode_q;
        tt_d     = tt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WRITE;
                    idx_d   = 2'd0;
                    mode_d  = mode;
                    tt_d    = test_times;
                end
            end
            S_WRITE: begin
                // AW and W retire independently; leave once both have handshaken.
                if ((aw_ok_q || M_AWREADY) && (w_ok_q || M_WREADY)) begin
                    state_d = S_BRESP;
                end else begin
                    aw_ok_d = aw_ok_q || M_AWREADY;
                    w_ok_d  = w_ok_q || M_WREADY;
                end
            end
            S_BRESP: begin
                if (M_BVALID) begin
                    if (M_BRESP != 2'b00) begin
                        state_d = S_ERR;
                    end else if (idx_q == 2'd3) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_WRITE;
                        idx_d   = idx_q + 2'd1;
                    end
                end
            end
            S_GAP: begin
                if (timeout) begin
                    state_d  = S_ERR;
                    status_d = 32'hDEAD_0000;
                end else if (gap_q >= GAP_LIM) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (M_ARREADY) state_d = S_RDATA;
            end
            S_RDATA: begin
                if (M_RVALID) begin
                    status_d = M_RDATA;
                    if (M_RRESP != 2'b00 || M_RDATA[1]) state_d = S_ERR;
                    else if (M_RDATA[0])                state_d = S_DONE;
                    else                                state_d = S_GAP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        M_AWVALID = 1'b0;
        M_WVALID  = 1'b0;
        M_AWADDR  = '0;
        M_WDATA   = '0;
        M_BREADY  = (state_q == S_BRESP);
        M_ARVALID = (state_q == S_READ);
        M_ARADDR  = (state_q == S_READ) ? BASE_ADDR + OFF_STATUS : '0;
        M_RREADY  = (state_q == S_RDATA);
        M_AWPROT  = 3'b000;
        M_ARPROT  = 3'b000;
        M_WSTRB   = 4'hF;
        busy      = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
        done      = (state_q == S_DONE);
        error     = (state_q == S_ERR);
        status    = status_q;
        if (state_q == S_WRITE) begin
            M_AWVALID = !aw_ok_q;
            M_WVALID  = !w_ok_q;
            unique case (idx_q)
                2'd0: begin M_AWADDR = BASE_ADDR + OFF_MODE;  M_WDATA = {30'd0, mode_q}; end
                2'd1: begin M_AWADDR = BASE_ADDR + OFF_TT_LO; M_WDATA = tt_q[31:0];      end
                2'd2: begin M_AWADDR = BASE_ADDR + OFF_TT_HI; M_WDATA = tt_q[63:32];     end
                default: begin M_AWADDR = BASE_ADDR + OFF_CTRL; M_WDATA = 32'd1;         end
            endcase
        end
    end

endmodule

// File: tb/tb_paillier_lite_cfg_master.sv
// Bench for paillier_lite_cfg_master: reactive AXI-Lite slave model with a write scoreboard and a vector table.
module tb_paillier_lite_cfg_master;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [63:0] test_times = '0;
    logic        busy, done, error;
    logic [31:0] status;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
    logic [2:0]  M_AWPROT, M_ARPROT;
    logic [3:0]  M_WSTRB;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
    logic [1:0]  M_BRESP, M_RRESP;
    logic        M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

    always #5 clk = ~clk;

    paillier_lite_cfg_master #(
        .ADDR_WIDTH(32), .BASE_ADDR(BASE), .POLL_GAP(16), .TIMEOUT_CYCLES(200)
    ) dut (
        .S_LITE_AXI_ACLK(clk), .S_LITE_AXI_ARESETN(rst),
        .start(start), .mode(mode), .test_times(test_times),
        .busy(busy), .done(done), .error(error), .status(status),
        .M_AWADDR(M_AWADDR), .M_AWPROT(M_AWPROT), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    // Slave configuration and observation counters
    int          aw_delay = 0;
    int          berr_at = 0;
    int          done_at = 0;
    logic [31:0] done_val = 32'd1;
    bit          ar_hold = 1'b0;
    int          nwr = 0, nrd = 0, dup_w = 0, stab_err = 0, aw_cnt = 0;
    logic        bvalid = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic [31:0] rdata = '0;
    bit          got_aw = 1'b0, got_w = 1'b0, aw_pend = 1'b0;
    logic [31:0] wr_addr = '0, wr_data = '0, aw_pend_addr = '0;
    bit          s_aw, s_w, s_b, s_ar, s_r, s_awv;
    logic [31:0] s_awa, s_wd, s_ara;

    assign M_AWREADY = (aw_cnt >= aw_delay);
    assign M_WREADY  = 1'b1;
    assign M_BVALID  = bvalid;
    assign M_BRESP   = bresp;
    assign M_ARREADY = !ar_hold;
    assign M_RVALID  = rvalid;
    assign M_RDATA   = rdata;
    assign M_RRESP   = 2'b00;

    initial begin
        forever begin
            @(posedge clk);
            s_aw  = M_AWVALID && M_AWREADY;
            s_w   = M_WVALID && M_WREADY;
            s_b   = M_BVALID && M_BREADY;
            s_ar  = M_ARVALID && M_ARREADY;
            s_r   = M_RVALID && M_RREADY;
            s_awv = M_AWVALID;
            s_awa = M_AWADDR;
            s_wd  = M_WDATA;
            s_ara = M_ARADDR;
            #1;
            if (rst) begin
                bvalid = 0; rvalid = 0; got_aw = 0; got_w = 0; aw_cnt = 0; aw_pend = 0;
            end else begin
                if (aw_pend && (!s_awv || s_awa != aw_pend_addr)) stab_err++;
                aw_pend      = s_awv && !s_aw;
                aw_pend_addr = s_awa;
                if (s_aw) begin got_aw = 1; wr_addr = s_awa; aw_cnt = 0; end
                else if (s_awv) aw_cnt++;
                if (s_w) begin
                    if (got_w) dup_w++;
                    got_w = 1; wr_data = s_wd;
                end
                if (s_b) bvalid = 0;
                if (got_aw && got_w && !bvalid) begin
                    nwr++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_write_addr", {32'd0, wr_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("wr_addr", {32'd0, wr_addr}, {32'd0, e.addr});
                        check("wr_data", {32'd0, wr_data}, {32'd0, e.data});
                    end
                    bvalid = 1;
                    bresp  = (nwr == berr_at) ? 2'b10 : 2'b00;
                    got_aw = 0; got_w = 0;
                end
                if (s_r) rvalid = 0;
                if (s_ar) begin
                    nrd++;
                    check("rd_addr", {32'd0, s_ara}, {32'd0, BASE + 32'h10});
                    rvalid = 1;
                    rdata  = (done_at != 0 && nrd == done_at) ? done_val : 32'd0;
                end
            end
        end
    end

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] tt;
        int          aw_delay;
        int          berr_at;
        int          done_at;
        logic [31:0] done_val;
        bit          exp_done;
        bit          exp_err;
        logic [31:0] exp_status;
        int          exp_wr;
        int          exp_rd;
    } vec_t;
    vec_t vecs[7];

    task automatic push_writes(input logic [1:0] m, input logic [63:0] tt);
        exp_q.push_back('{BASE + 32'h00, {30'd0, m}});
        exp_q.push_back('{BASE + 32'h08, tt[31:0]});
        exp_q.push_back('{BASE + 32'h0C, tt[63:32]});
        exp_q.push_back('{BASE + 32'h04, 32'd1});
    endtask

    task automatic launch(input logic [1:0] m, input logic [63:0] tt);
        nwr = 0; nrd = 0; dup_w = 0; stab_err = 0;
        push_writes(m, tt);
        @(negedge clk);
        start = 1; mode = m; test_times = tt;
        @(negedge clk);
        start = 0; mode = ~m; test_times = ~tt;
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int   cyc;
        logic got_done, got_err;
        logic [31:0] st;
        aw_delay = v.aw_delay; berr_at = v.berr_at; done_at = v.done_at; done_val = v.done_val;
        launch(v.mode, v.tt);
        cyc = 0;
        while (!(done || error) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (!(done || error)) begin
            n_cmp++; n_err++;
            $display("FAIL vec%0d_completion: no done/error within 3000 cycles", id);
        end
        got_done = done; got_err = error; st = status;
        start = 1;
        @(negedge clk);
        start = 0;
        check($sformatf("vec%0d_done", id), {63'd0, got_done}, {63'd0, v.exp_done});
        check($sformatf("vec%0d_error", id), {63'd0, got_err}, {63'd0, v.exp_err});
        check($sformatf("vec%0d_status", id), {32'd0, st}, {32'd0, v.exp_status});
        check($sformatf("vec%0d_busy_low", id), {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        check($sformatf("vec%0d_no_restart", id), {63'd0, busy}, 64'd0);
        check($sformatf("vec%0d_writes", id), 64'(nwr), 64'(v.exp_wr));
        check($sformatf("vec%0d_reads", id), 64'(nrd), 64'(v.exp_rd));
        check($sformatf("vec%0d_dup_w", id), 64'(dup_w), 64'd0);
        check($sformatf("vec%0d_aw_stable", id), 64'(stab_err), 64'd0);
        check($sformatf("vec%0d_pending_writes", id), 64'(exp_q.size()), 64'(4 - v.exp_wr));
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        #1;
        check("rst_awvalid", {63'd0, M_AWVALID}, 64'd0);
        check("rst_wvalid", {63'd0, M_WVALID}, 64'd0);
        check("rst_arvalid", {63'd0, M_ARVALID}, 64'd0);
        check("rst_bready", {63'd0, M_BREADY}, 64'd0);
        check("rst_rready", {63'd0, M_RREADY}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done_error", {62'd0, done, error}, 64'd0);
        check("rst_status", {32'd0, status}, 64'd0);
        check("rst_awaddr_wdata", {M_AWADDR, M_WDATA}, 64'd0);
        check("prot_strb", {53'd0, M_AWPROT, M_ARPROT, M_WSTRB}, 64'h00F);
        repeat (2) @(negedge clk);
        rst = 0;

        vecs[0] = '{2'b00, 64'd3,             0, 0, 3, 32'd1,          1, 0, 32'd1,          4, 3};
        vecs[1] = '{2'b01, 64'h1_0000_0005,   0, 0, 1, 32'd1,          1, 0, 32'd1,          4, 1};
        vecs[2] = '{2'b10, 64'd7,             5, 0, 2, 32'd1,          1, 0, 32'd1,          4, 2};
        vecs[3] = '{2'b11, 64'd9,             0, 2, 1, 32'd1,          0, 1, 32'd1,          2, 0};
        vecs[4] = '{2'b00, 64'd4,             0, 0, 2, 32'd2,          0, 1, 32'd2,          4, 2};
        vecs[5] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 32'd3,    0, 1, 32'd3,          4, 1};
        vecs[6] = '{2'b10, 64'h8765_4321_0ABC_DEF0, 3, 0, 1, 32'h8000_0001, 1, 0, 32'h8000_0001, 4, 1};
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset while a status read is stalled on ARREADY.
        aw_delay = 0; berr_at = 0; done_at = 0; ar_hold = 1;
        launch(2'b00, 64'd2);
        cyc = 0;
        while (!M_ARVALID && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("rd_stall_arvalid", {63'd0, M_ARVALID}, 64'd1);
        rst = 1;
        #1;
        check("rst_mid_read_arvalid", {63'd0, M_ARVALID}, 64'd0);
        check("rst_mid_read_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        check("rst_mid_read_arvalid_edge", {63'd0, M_ARVALID}, 64'd0);
        @(negedge clk);
        rst = 0; ar_hold = 0;
        check("rst_mid_read_writes", 64'(nwr), 64'd4);
        check("rst_mid_read_reads", 64'(nrd), 64'd0);
        exp_q.delete();
        run_vec(vecs[0], 7);

`ifdef PAILLIER_CFG_TIMEOUT_EN
        done_at = 0;
        launch(2'b11, 64'd5);
        cyc = 0;
        while (!(done || error) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_error", {63'd0, error}, 64'd1);
        check("timeout_done", {63'd0, done}, 64'd0);
        check("timeout_status", {32'd0, status}, 64'hDEAD_0000);
        @(negedge clk);
        check("timeout_busy_low", {63'd0, busy}, 64'd0);
        exp_q.delete();
`else
        done_at = 0;
        launch(2'b11, 64'd5);
        repeat (10000) @(negedge clk);
        check("no_timeout_busy", {63'd0, busy}, 64'd1);
        check("no_timeout_error", {62'd0, done, error}, 64'd0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        exp_q.delete();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
